pingpong_window_reader: RTL and testbench

PINGPONG_WINDOW_READER -- requirements
Module: pingpong_window_reader

---
 rtl/pingpong_window_reader_pkg.sv | 23 ++
 rtl/pingpong_window_reader_shift_reg.sv | 39 +++
 rtl/pingpong_window_reader.sv | 188 ++++++++++++++++++
 tb/tb_pingpong_window_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_window_reader_pkg.sv
// Shared types and constants for the ping-pong window reader.
// State encoding, address width and windows-per-bank helper.
package pingpong_window_reader_pkg;

  localparam int ADDR_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN,
    RELEASE
  } state_t;

  function automatic int win_per_bank(
    input int lw,
    input int k,
    input bit pad
  );
    return pad ? lw : lw - k + 1;
  endfunction

endpackage

// File: rtl/pingpong_window_reader_shift_reg.sv
// K-column window register for the ping-pong window reader.
// Newest column enters at c=K-1; older columns move toward c=0.
module window_shift_reg
  import pingpong_window_reader_pkg::*;
#(
  parameter int K  = 3,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [K*DW-1:0]   col_in,
  output logic [K*K*DW-1:0] win_out
);

  logic [K*DW-1:0] cols [K];

  // column storage: clear between banks, shift on enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < K; c++) cols[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < K; c++) cols[c] <= '0;
    end else if (shift_en) begin
      for (int c = 0; c < K - 1; c++) cols[c] <= cols[c+1];
      cols[K-1] <= col_in;
    end
  end

  // flatten: pixel (r,c) lands at slice r*K+c
  always_comb begin
    win_out = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_out[(r*K+c)*DW +: DW] = cols[c][r*DW +: DW];
  end

endmodule

// File: rtl/pingpong_window_reader.sv
// Reads K-line ping-pong banks column by column into KxK windows.
// Optional zero padding: define WINDOW_READER_ZERO_PAD_EN.
module pingpong_window_reader
  import pingpong_window_reader_pkg::*;
#(
  parameter int NUM_LINES  = 3,
  parameter int DATA_WIDTH = 16,
  parameter int LINE_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  bank_done,
  input  logic                                  bank_done_id,
  output logic                                  rd_en,
  output logic                                  rd_bank,
  output logic [ADDR_W-1:0]                     rd_addr,
  input  logic [NUM_LINES*DATA_WIDTH-1:0]       rd_data,
  output logic [NUM_LINES*NUM_LINES*DATA_WIDTH-1:0] win_data,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic                                  bank_release,
  output logic                                  overflow,
  output logic                                  busy
);

  localparam int K   = NUM_LINES;
  localparam int CDW = K * DATA_WIDTH;
  localparam int CW  = ADDR_W + 1;
`ifdef WINDOW_READER_ZERO_PAD_EN
  localparam int PAD    = (K - 1) / 2;
  localparam bit PAD_EN = 1'b1;
  localparam int NCOL   = LINE_WIDTH + 2 * PAD;
`else
  localparam bit PAD_EN = 1'b0;
  localparam int NCOL   = LINE_WIDTH;
`endif
  localparam int NWIN = win_per_bank(LINE_WIDTH, K, PAD_EN);

  localparam logic [CW-1:0] LW_C   = CW'(LINE_WIDTH);
  localparam logic [CW-1:0] K_C    = CW'(K);
  localparam logic [CW-1:0] NCOL_C = CW'(NCOL);
  localparam logic [CW-1:0] NWIN_C = CW'(NWIN);

  state_t          state, nxt;
  logic [1:0]      pend;
  logic            turn;
  logic [CW-1:0]   col_cnt, sh_cnt, win_cnt;
  logic            inflight;
  logic [CDW-1:0]  fifo [2];
  logic            wp, rp;
  logic [1:0]      cnt;

  logic            active, is_pad, head_ok, shift;
  logic            push, pop, acc, all_done, rd_last, rel;
  logic [CDW-1:0]  head;
  logic [1:0]      set_v, clr_v;

  assign active = (state == PRIME) || (state == STREAM) ||
                  (state == DRAIN);
  assign rd_en  = ((state == PRIME) || (state == STREAM)) &&
                  (col_cnt < LW_C) &&
                  (({1'b0, inflight} + cnt) < 2'd2);
  assign rd_addr = col_cnt[ADDR_W-1:0];
  assign rd_last = rd_en && (col_cnt == LW_C - 1'b1);

`ifdef WINDOW_READER_ZERO_PAD_EN
  localparam logic [CW-1:0] PAD_C = CW'(PAD);
  assign is_pad = (sh_cnt < PAD_C) || (sh_cnt >= PAD_C + LW_C);
`else
  assign is_pad = 1'b0;
`endif

  // head of the column stream: pad zeros, skid entry or bypassed read
  assign head    = is_pad ? '0 : ((cnt != 2'd0) ? fifo[rp] : rd_data);
  assign head_ok = is_pad || (cnt != 2'd0) || inflight;
  assign shift   = active && (sh_cnt < NCOL_C) && head_ok &&
                   (!win_valid || win_ready);
  assign pop     = shift && !is_pad && (cnt != 2'd0);
  assign push    = inflight && !(shift && !is_pad && (cnt == 2'd0));

  assign acc      = win_valid && win_ready;
  assign all_done = (win_cnt == NWIN_C) ||
                    (acc && (win_cnt == NWIN_C - 1'b1));

  assign rel          = (state == RELEASE);
  assign bank_release = rel;
  assign busy         = (state != IDLE);

  assign set_v = bank_done ? (bank_done_id ? 2'b10 : 2'b01) : 2'b00;
  assign clr_v = rel ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (pend[turn]) nxt = PRIME;
      PRIME:   if (sh_cnt >= K_C) nxt = STREAM;
      STREAM:  if (rd_last || (col_cnt == LW_C)) nxt = DRAIN;
      DRAIN:   if (all_done) nxt = RELEASE;
      RELEASE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // bank bookkeeping: pending flags, overflow, turn, bank select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= 2'b00;
      overflow <= 1'b0;
      turn     <= 1'b0;
      rd_bank  <= 1'b0;
    end else begin
      pend <= (pend & ~clr_v) | set_v;
      if (|(set_v & pend & ~clr_v)) overflow <= 1'b1;
      if ((state == IDLE) && pend[turn]) rd_bank <= turn;
      if (rel) turn <= ~turn;
    end
  end

  // column, shift and window counters plus read-in-flight flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt  <= '0;
      sh_cnt   <= '0;
      win_cnt  <= '0;
      inflight <= 1'b0;
    end else if (state == IDLE) begin
      col_cnt  <= '0;
      sh_cnt   <= '0;
      win_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) col_cnt <= col_cnt + 1'b1;
      if (shift) sh_cnt  <= sh_cnt + 1'b1;
      if (acc)   win_cnt <= win_cnt + 1'b1;
    end
  end

  // two-entry skid FIFO for columns that cannot shift yet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      cnt     <= 2'd0;
    end else if (state == IDLE) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo[wp] <= rd_data;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // window valid: set once K columns are in, held while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               win_valid <= 1'b0;
    else if (state == IDLE)  win_valid <= 1'b0;
    else if (shift)          win_valid <= (sh_cnt + 1'b1) >= K_C;
    else if (acc)            win_valid <= 1'b0;
  end

  window_shift_reg #(
    .K  (K),
    .DW (DATA_WIDTH)
  ) u_win (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift),
    .clear    (state == IDLE),
    .col_in   (head),
    .win_out  (win_data)
  );

endmodule

// File: tb/tb_pingpong_window_reader.sv
// Directed bench for pingpong_window_reader (K=3, 8-pixel lines).
// Bank model returns pixel 16*r+c (+256 for bank 1) one cycle late.
module tb_pingpong_window_reader;
  import pingpong_window_reader_pkg::*;

  localparam int K  = 3;
  localparam int DW = 16;
  localparam int LW = 8;
`ifdef WINDOW_READER_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int NWIN = LW + 2 * PAD - K + 1;
  localparam int CW   = K * DW;
  localparam int WW   = K * K * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bank_done = 1'b0;
  logic          bank_done_id = 1'b0;
  logic          win_ready = 1'b1;
  logic          rd_en, rd_bank, win_valid;
  logic          bank_release, overflow, busy;
  logic [ADDR_W-1:0] rd_addr;
  logic [CW-1:0] rd_data = '0;
  logic [WW-1:0] win_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [WW-1:0] acc_data [$];
  logic          acc_bank [$];
  int            acc_cyc  [$];
  logic          rel_bank [$];
  int            rd_list  [$];
  logic          stall_q = 1'b0;
  logic [WW-1:0] stall_d = '0;
  int b0, r0;
  logic [WW-1:0] fw;

  always #5 clk = ~clk;

  pingpong_window_reader #(
    .NUM_LINES  (K),
    .DATA_WIDTH (DW),
    .LINE_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bank_done    (bank_done),
    .bank_done_id (bank_done_id),
    .rd_en        (rd_en),
    .rd_bank      (rd_bank),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .win_data     (win_data),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .bank_release (bank_release),
    .overflow     (overflow),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input logic b, input int r,
                                        input int c);
    return DW'(16 * r + c + (b ? 256 : 0));
  endfunction

  function automatic logic [CW-1:0] col_of(input logic b, input int c);
    logic [CW-1:0] v;
    for (int r = 0; r < K; r++) v[r*DW +: DW] = pix(b, r, c);
    return v;
  endfunction

  function automatic logic [WW-1:0] exp_win(input logic b, input int j);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        int x;
        x = j + c - PAD;
        if (x >= 0 && x < LW) w[(r*K+c)*DW +: DW] = pix(b, r, x);
      end
    return w;
  endfunction

  always @(posedge clk)
    rd_data <= rd_en ? col_of(rd_bank, int'(rd_addr)) : {K{16'hdead}};

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (stall_q) begin
        chk("stall_valid", win_valid, 1);
        chk("stall_data", win_data, stall_d);
      end
      stall_q = win_valid && !win_ready;
      stall_d = win_data;
      if (win_valid && win_ready) begin
        acc_data.push_back(win_data);
        acc_bank.push_back(rd_bank);
        acc_cyc.push_back(cyc);
      end
      if (bank_release) rel_bank.push_back(rd_bank);
      if (rd_en) rd_list.push_back(int'(rd_addr));
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic id);
    bank_done    = 1'b1;
    bank_done_id = id;
    tick();
    bank_done    = 1'b0;
  endtask

  task automatic wait_rel(input int n, input bit toggle);
    for (int i = 0; i < 400 && rel_bank.size() < n; i++) begin
      if (toggle) win_ready = ~win_ready;
      tick();
    end
    win_ready = 1'b1;
    chk("release_seen", rel_bank.size(), n);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_win_data"}, win_data, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_release"}, bank_release, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic chk_wins(input int base, input logic b,
                          input string tag);
    for (int j = 0; j < NWIN; j++) begin
      if (base + j < acc_data.size()) begin
        chk({tag, "_data"}, acc_data[base+j], exp_win(b, j));
        chk({tag, "_bank"}, acc_bank[base+j], b);
      end else begin
        chk({tag, "_missing"}, 0, 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    reset = 1'b0;
    tick();

    // single bank, ready held high
    b0 = acc_data.size();
    r0 = rd_list.size();
    pulse(0);
    wait_rel(1, 1'b0);
    chk("A_nwin", acc_data.size() - b0, NWIN);
    chk_wins(b0, 1'b0, "A_win");
    for (int j = 1; j < NWIN && b0 + j < acc_cyc.size(); j++)
      chk("A_consec", acc_cyc[b0+j] - acc_cyc[b0], j);
`ifndef WINDOW_READER_ZERO_PAD_EN
    fw = {16'd34, 16'd33, 16'd32, 16'd18, 16'd17,
          16'd16, 16'd2, 16'd1, 16'd0};
    if (acc_data.size() > b0) chk("A_first", acc_data[b0], fw);
`endif
    chk("A_rel_bank", rel_bank[0], 0);
    chk("A_nreads", rd_list.size() - r0, LW);
    for (int j = 0; j < LW && r0 + j < rd_list.size(); j++)
      chk("A_addr", rd_list[r0+j], j);
    tick();
    chk("A_idle", busy, 0);

    // bank 1 with ready toggling every cycle
    b0 = acc_data.size();
    pulse(1);
    wait_rel(2, 1'b1);
    chk("B_nwin", acc_data.size() - b0, NWIN);
    chk_wins(b0, 1'b1, "B_win");
    chk("B_rel_bank", rel_bank[1], 1);

    // bank 1 done before bank 0: bank 0 still goes first
    b0 = acc_data.size();
    pulse(1);
    pulse(0);
    wait_rel(4, 1'b0);
    chk("C_nwin", acc_data.size() - b0, 2 * NWIN);
    chk_wins(b0, 1'b0, "C_win0");
    chk_wins(b0 + NWIN, 1'b1, "C_win1");
    chk("C_rel0", rel_bank[2], 0);
    chk("C_rel1", rel_bank[3], 1);
    chk("C_no_ovf", overflow, 0);

    // repeat completion on a pending bank
    b0 = acc_data.size();
    pulse(0);
    tick();
    pulse(0);
    chk("D_ovf", overflow, 1);
    wait_rel(5, 1'b0);
    repeat (4) tick();
    chk("D_ovf_hold", overflow, 1);
    chk("D_nwin", acc_data.size() - b0, NWIN);
    chk("D_idle", busy, 0);

    // reset in the middle of a bank
    b0 = acc_data.size();
    pulse(1);
    for (int i = 0; i < 200 && acc_data.size() - b0 < 3; i++) tick();
    chk("E_three", acc_data.size() - b0, 3);
    reset = 1'b1;
    tick();
    chk_reset("E_rst");
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("E_no_release", rel_bank.size(), 5);
    chk("E_idle", busy, 0);
    b0 = acc_data.size();
    r0 = rd_list.size();
    pulse(0);
    wait_rel(6, 1'b0);
    if (rd_list.size() > r0) chk("E_addr0", rd_list[r0], 0);
    else chk("E_addr0_missing", 0, 1);
    chk("E_nwin", acc_data.size() - b0, NWIN);
    chk_wins(b0, 1'b0, "E_win");
    chk("E_rel_bank", rel_bank[5], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
